// File: rtl/countdown_timer.sv
// countdown_timer: BCD mm:ss countdown driven by an asynchronous 1 Hz sec_clk, with load/start/pause control, expiry pulse and low-time warning
module countdown_timer #(
  parameter int WARN_SEC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_clk,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done_pulse,
  output logic       warn
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  state_t state, state_n;
  logic sync1, sync2, prev, tick, zero, load_ok, done_n, warn_n;
  logic [7:0] min_n, sec_n, sec_bin;
  assign tick = sync2 & ~prev;
  assign zero = min_bcd == 8'h00 && sec_bcd == 8'h00;
  assign load_ok = load_min[3:0] <= 4'd9 && load_min[7:4] <= 4'd5 && load_sec[3:0] <= 4'd9 && load_sec[7:4] <= 4'd5;
  assign sec_bin = {4'b0, sec_n[7:4]} * 8'd10 + {4'b0, sec_n[3:0]};
  assign warn_n = (state_n == RUN || state_n == PAUSE) && min_n == 8'h00 && sec_n != 8'h00 && sec_bin <= 8'(WARN_SEC);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      prev       <= 1'b0;
      state      <= IDLE;
      min_bcd    <= 8'h00;
      sec_bcd    <= 8'h00;
      running    <= 1'b0;
      expired    <= 1'b0;
      done_pulse <= 1'b0;
      warn       <= 1'b0;
    end else begin
      sync1      <= sec_clk;
      sync2      <= sync1;
      prev       <= sync2;
      state      <= state_n;
      min_bcd    <= min_n;
      sec_bcd    <= sec_n;
      running    <= state_n == RUN;
      expired    <= state_n == DONE;
      done_pulse <= done_n;
      warn       <= warn_n;
    end
  end
  always_comb begin
    state_n = state;
    min_n   = min_bcd;
    sec_n   = sec_bcd;
    done_n  = 1'b0;
    if (load && state != RUN) begin
      if (load_ok) begin
        min_n   = load_min;
        sec_n   = load_sec;
        state_n = IDLE;
      end
    end else if (start && (state == IDLE || state == PAUSE)) begin
      state_n = zero ? state : RUN;
    end else if (pause && state == RUN) begin
      state_n = PAUSE;
    end else if (tick && state == RUN && !zero) begin
      sec_n = sec_bcd[3:0] != 4'd0 ? sec_bcd - 8'd1 : sec_bcd[7:4] != 4'd0 ? {sec_bcd[7:4] - 4'd1, 4'd9} : 8'h59;
      min_n = sec_bcd != 8'h00 ? min_bcd : min_bcd[3:0] != 4'd0 ? min_bcd - 8'd1 : {min_bcd[7:4] - 4'd1, 4'd9};
      done_n  = min_n == 8'h00 && sec_n == 8'h00;
      state_n = done_n ? DONE : RUN;
    end
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer
module tb_countdown_timer;
  logic clk = 1'b0, reset = 1'b1, sec_clk = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] load_min = 8'h00, load_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic running, expired, done_pulse, warn;
  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp_v;
  always #10 clk = ~clk;
  countdown_timer #(.WARN_SEC(10)) dut (
    .clk(clk), .reset(reset), .sec_clk(sec_clk), .load(load), .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .running(running),
    .expired(expired), .done_pulse(done_pulse), .warn(warn)
  );
  task automatic ctrl(input logic l, input logic s, input logic p, input logic [7:0] m, input logic [7:0] sc);
    load = l; start = s; pause = p; load_min = m; load_sec = sc;
    @(posedge clk); #1;
    load = 1'b0; start = 1'b0; pause = 1'b0;
  endtask
  task automatic tick_rise;
    sec_clk = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask
  task automatic tick_fall;
    repeat (7) @(posedge clk);
    #1 sec_clk = 1'b0;
    repeat (10) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({min_bcd, sec_bcd, running, expired, done_pulse, warn} !== 20'h0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=00000", {min_bcd, sec_bcd, running, expired, done_pulse, warn});
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask
  task automatic test_basic;
    ctrl(1, 0, 0, 8'h00, 8'h03);
    checks++;
    if ({min_bcd, sec_bcd, running} !== {16'h0003, 1'b0}) begin
      failures++;
      $display("FAIL basic_load got=%h%h r=%b exp=0003 r=0", min_bcd, sec_bcd, running);
    end
    ctrl(0, 1, 0, 8'h00, 8'h00);
    checks++;
    if (running !== 1'b1) begin
      failures++;
      $display("FAIL basic_running got=%b exp=1", running);
    end
    exp_q.push_back(16'h0002); exp_q.push_back(16'h0001); exp_q.push_back(16'h0000);
    sec_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({min_bcd, sec_bcd} !== 16'h0003) begin
      failures++;
      $display("FAIL basic_early_update got=%h%h exp=0003", min_bcd, sec_bcd);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick_rise;
      exp_v = exp_q.pop_front();
      checks++;
      if ({min_bcd, sec_bcd} !== exp_v) begin
        failures++;
        $display("FAIL basic_count%0d got=%h%h exp=%h", i, min_bcd, sec_bcd, exp_v);
      end
      if (i == 2) begin
        checks++;
        if ({done_pulse, expired, running} !== 3'b110) begin
          failures++;
          $display("FAIL basic_done got=dp%b ex%b run%b exp=dp1 ex1 run0", done_pulse, expired, running);
        end
        @(posedge clk); #1;
        checks++;
        if ({done_pulse, expired} !== 2'b01) begin
          failures++;
          $display("FAIL basic_pulse_width got=dp%b ex%b exp=dp0 ex1", done_pulse, expired);
        end
      end
      tick_fall;
    end
    exp_q.push_back(16'h0000);
    tick_rise;
    exp_v = exp_q.pop_front();
    checks++;
    if ({min_bcd, sec_bcd, done_pulse} !== {exp_v, 1'b0}) begin
      failures++;
      $display("FAIL basic_no_wrap got=%h%h dp=%b exp=%h dp=0", min_bcd, sec_bcd, done_pulse, exp_v);
    end
    tick_fall;
  endtask
  task automatic test_warn;
    ctrl(1, 0, 0, 8'h01, 8'h00);
    checks++;
    if ({expired, warn} !== 2'b00) begin
      failures++;
      $display("FAIL warn_load got=ex%b w%b exp=ex0 w0", expired, warn);
    end
    ctrl(0, 1, 0, 8'h00, 8'h00);
    for (int n = 59; n >= 0; n--) begin
      exp_q.push_back({8'h00, 4'(n / 10), 4'(n % 10)});
      tick_rise;
      exp_v = exp_q.pop_front();
      checks++;
      if ({min_bcd, sec_bcd} !== exp_v || warn !== (n > 0 && n <= 10)) begin
        failures++;
        $display("FAIL warn_step%0d got=%h%h w=%b exp=%h w=%b", n, min_bcd, sec_bcd, warn, exp_v, n > 0 && n <= 10);
      end
      tick_fall;
    end
  endtask
  task automatic test_pause;
    ctrl(1, 0, 0, 8'h00, 8'h05);
    ctrl(0, 1, 0, 8'h00, 8'h00);
    exp_q.push_back(16'h0004); exp_q.push_back(16'h0003);
    for (int i = 0; i < 2; i++) begin
      tick_rise;
      exp_v = exp_q.pop_front();
      checks++;
      if ({min_bcd, sec_bcd} !== exp_v) begin
        failures++;
        $display("FAIL pause_run%0d got=%h%h exp=%h", i, min_bcd, sec_bcd, exp_v);
      end
      tick_fall;
    end
    ctrl(0, 0, 1, 8'h00, 8'h00);
    checks++;
    if ({running, warn} !== 2'b01) begin
      failures++;
      $display("FAIL pause_state got=r%b w%b exp=r0 w1", running, warn);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(16'h0003);
      tick_rise;
      exp_v = exp_q.pop_front();
      checks++;
      if ({min_bcd, sec_bcd} !== exp_v) begin
        failures++;
        $display("FAIL pause_hold%0d got=%h%h exp=%h", i, min_bcd, sec_bcd, exp_v);
      end
      tick_fall;
    end
    ctrl(0, 1, 0, 8'h00, 8'h00);
    exp_q.push_back(16'h0002);
    tick_rise;
    exp_v = exp_q.pop_front();
    checks++;
    if ({min_bcd, sec_bcd, running} !== {exp_v, 1'b1}) begin
      failures++;
      $display("FAIL pause_resume got=%h%h r=%b exp=%h r=1", min_bcd, sec_bcd, running, exp_v);
    end
    tick_fall;
    ctrl(0, 0, 1, 8'h00, 8'h00);
  endtask
  task automatic test_reject;
    ctrl(1, 0, 0, 8'h6A, 8'h75);
    checks++;
    if ({min_bcd, sec_bcd, running, warn} !== {16'h0002, 2'b01}) begin
      failures++;
      $display("FAIL reject_bad_load got=%h%h r=%b w=%b exp=0002 r=0 w=1", min_bcd, sec_bcd, running, warn);
    end
    ctrl(1, 0, 0, 8'h00, 8'h04);
    ctrl(1, 1, 1, 8'h00, 8'h07);
    checks++;
    if ({min_bcd, sec_bcd, running, warn} !== {16'h0007, 2'b00}) begin
      failures++;
      $display("FAIL reject_priority got=%h%h r=%b w=%b exp=0007 r=0 w=0", min_bcd, sec_bcd, running, warn);
    end
    exp_q.push_back(16'h0007);
    tick_rise;
    exp_v = exp_q.pop_front();
    checks++;
    if ({min_bcd, sec_bcd} !== exp_v) begin
      failures++;
      $display("FAIL reject_idle_tick got=%h%h exp=%h", min_bcd, sec_bcd, exp_v);
    end
    tick_fall;
  endtask
  task automatic test_zero_and_run_load;
    ctrl(1, 0, 0, 8'h00, 8'h00);
    ctrl(0, 1, 0, 8'h00, 8'h00);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL zero_start got=%b exp=0", running);
    end
    ctrl(1, 0, 0, 8'h00, 8'h06);
    ctrl(0, 1, 0, 8'h00, 8'h00);
    exp_q.push_back(16'h0005);
    tick_rise;
    exp_v = exp_q.pop_front();
    checks++;
    if ({min_bcd, sec_bcd} !== exp_v) begin
      failures++;
      $display("FAIL run_first got=%h%h exp=%h", min_bcd, sec_bcd, exp_v);
    end
    tick_fall;
    ctrl(1, 0, 0, 8'h00, 8'h30);
    checks++;
    if ({min_bcd, sec_bcd, running} !== {16'h0005, 1'b1}) begin
      failures++;
      $display("FAIL run_load_ignored got=%h%h r=%b exp=0005 r=1", min_bcd, sec_bcd, running);
    end
    exp_q.push_back(16'h0004);
    tick_rise;
    exp_v = exp_q.pop_front();
    checks++;
    if ({min_bcd, sec_bcd} !== exp_v) begin
      failures++;
      $display("FAIL run_continue got=%h%h exp=%h", min_bcd, sec_bcd, exp_v);
    end
    tick_fall;
  endtask
  task automatic test_reset_mid_run;
    ctrl(0, 0, 1, 8'h00, 8'h00);
    ctrl(1, 0, 0, 8'h00, 8'h08);
    ctrl(0, 1, 0, 8'h00, 8'h00);
    exp_q.push_back(16'h0007);
    tick_rise;
    exp_v = exp_q.pop_front();
    checks++;
    if ({min_bcd, sec_bcd, running} !== {exp_v, 1'b1}) begin
      failures++;
      $display("FAIL rst_pre got=%h%h r=%b exp=%h r=1", min_bcd, sec_bcd, running, exp_v);
    end
    tick_fall;
    sec_clk = 1'b1;
    @(posedge clk);
    #5 reset = 1'b1;
    #1;
    checks++;
    if ({min_bcd, sec_bcd, running, expired, done_pulse, warn} !== 20'h0) begin
      failures++;
      $display("FAIL rst_async got=%h exp=00000", {min_bcd, sec_bcd, running, expired, done_pulse, warn});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    ctrl(1, 0, 0, 8'h00, 8'h09);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({min_bcd, sec_bcd, running, done_pulse} !== {16'h0009, 2'b00}) begin
      failures++;
      $display("FAIL rst_spurious_tick got=%h%h r=%b dp=%b exp=0009 r=0 dp=0", min_bcd, sec_bcd, running, done_pulse);
    end
    sec_clk = 1'b0;
    repeat (5) @(posedge clk);
    #1;
  endtask
  initial begin
    test_reset;
    test_basic;
    test_warn;
    test_pause;
    test_reject;
    test_zero_and_run_load;
    test_reset_mid_run;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WARN_SEC, default 10, warning threshold in seconds (legal range 0..59; 0 disables warn).
REQ-002 SHALL have port clk  input  1  system clock (50 MHz).
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port sec_clk  input  1  1 Hz square wave from the clock divider; treated as asynchronous.
REQ-005 SHALL have port load  input  1  load load_min/load_sec into the count.
REQ-006 SHALL have port load_min  input  8  minutes, two BCD digits [7:4] tens, [3:0] ones.
REQ-007 SHALL have port load_sec  input  8  seconds, two BCD digits.
REQ-008 SHALL have port start  input  1  start or resume the countdown.
REQ-009 SHALL have port pause  input  1  pause the countdown.
REQ-010 SHALL have port min_bcd  output  8  remaining minutes, BCD.
REQ-011 SHALL have port sec_bcd  output  8  remaining seconds, BCD.
REQ-012 SHALL have port running  output  1  high while state is RUN.
REQ-013 SHALL have port expired  output  1  high while state is DONE.
REQ-014 SHALL have port done_pulse  output  1  single-cycle pulse on reaching 00:00.
REQ-015 SHALL have port warn  output  1  low-time warning.

Function
REQ-016 SHALL pass sec_clk through a two-flop synchronizer, then an edge-detect flop; tick = sync2 & ~prev, one clk cycle wide.
REQ-017 SHALL apply a count update on the third clk edge after sec_clk rises: sync1 at edge k, sync2 at k+1, count update at k+2.
REQ-018 SHALL implement states IDLE, RUN, PAUSE, DONE, held in a 2-bit register.
REQ-019 SHALL accept load in IDLE, PAUSE and DONE: count <= load value, state -> IDLE, expired cleared.
REQ-020 SHALL ignore load while in RUN.
REQ-021 SHALL reject a load whose digit is >9 or whose tens digit is >5; count and state stay unchanged.
REQ-022 SHALL move IDLE or PAUSE -> RUN on start when the count is nonzero; start with count 00:00 is ignored.
REQ-023 SHALL move RUN -> PAUSE on pause; pause outside RUN is ignored.
REQ-024 SHALL ignore start while in RUN or DONE.
REQ-025 SHALL resolve simultaneous controls with priority load > start > pause.
REQ-026 SHALL decrement the count by one second on a tick only while in RUN at that edge.
REQ-027 SHALL discard ticks in every other state, with no accumulation; a tick coinciding with start or pause is discarded.
REQ-028 SHALL borrow in BCD on decrement: sec ones 0 -> 9 with tens-1; sec 00 -> 59 with min-1; min ones 0 -> 9 with tens-1.
REQ-029 SHALL, on the tick that takes the count from 00:01 to 00:00, enter DONE on the same edge.
REQ-030 SHALL assert done_pulse for exactly one cycle following that edge.
REQ-031 SHALL hold expired high from that edge until the next accepted load or reset.
REQ-032 SHALL NOT decrement below 00:00 and SHALL NOT wrap.
REQ-033 SHALL drive warn high when the state is RUN or PAUSE, min_bcd == 00, and 0 < seconds <= WARN_SEC.
REQ-034 SHALL NOT phase-align to start: the first decrement occurs on the next tick after start (first second may be short).
REQ-035 SHALL register all outputs directly.
REQ-036 SHALL assert no combinational path from inputs to outputs.

Reset
REQ-037 SHALL, on reset, set state IDLE, min_bcd=00, sec_bcd=00, running=expired=done_pulse=warn=0, and all synchronizer and edge flops to 0.
REQ-038 SHALL, on reset mid-RUN, abort immediately with no done_pulse.
REQ-039 SHALL treat a spurious tick after release (sec_clk already high) as discarded, since the state is IDLE.

Verification
REQ-040 Bench SHALL cover: sec_clk period 20 clk, load 00:03, start -> sec_bcd 03,02,01,00 at tick+2 edges; done_pulse 1 cycle; expired=1; running=0.
REQ-041 Bench SHALL cover: load 01:00, start, one tick -> 00:59; warn=0 until 00:10 (WARN_SEC=10), warn=1 through 00:01, warn=0 in DONE.
REQ-042 Bench SHALL cover: run from 00:05, pause after 2 ticks -> holds 00:03 over 5 ticks; start -> resumes 00:02 on next tick.
REQ-043 Bench SHALL cover: load 0x6A:0x75 -> rejected, count unchanged; load+start+pause in the same cycle from IDLE -> load applied, state IDLE.
REQ-044 Bench SHALL cover: start with 00:00 -> stays IDLE; load during RUN -> ignored, count continues.
REQ-045 Bench SHALL cover: reset asserted mid-RUN at 00:07 with sec_clk high -> outputs 0 immediately; after release, no decrement, state IDLE.
